// File: rtl/cache_pkg.sv
// Shared types and line geometry for the cache refill path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  localparam int WORDS_PER_LINE  = 4;
  localparam int WORD_SEL_W      = 2;
  // Byte-offset bits that sit below the word index in an address.
  localparam int WORD_OFFSET_LSB = 2;

endpackage

// File: rtl/refill_wrap_cnt.sv
// Beat counter plus critical-word start offset; yields wrapped word index.
// Latency: index/flags are combinational from the counter flops; updates take 1 cycle.
// Backpressure: none, counts only when inc is asserted.
module refill_wrap_cnt
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WORD_SEL_W-1:0] start_in,
  input  logic                  inc,
  output logic [WORD_SEL_W-1:0] word_idx,
  output logic                  first,
  output logic                  last
);

  logic [WORD_SEL_W-1:0] start_q, start_d;
  logic [WORD_SEL_W-1:0] beat_q, beat_d;

  // Clear wins over load, load wins over increment.
  always_comb begin
    start_d = start_q;
    beat_d  = beat_q;
    if (clr) begin
      start_d = '0;
      beat_d  = '0;
    end else if (load) begin
      start_d = start_in;
      beat_d  = '0;
    end else if (inc) begin
      beat_d = beat_q + WORD_SEL_W'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      beat_q  <= '0;
    end else begin
      start_q <= start_d;
      beat_q  <= beat_d;
    end
  end

  // Modulo-4 add gives the 3->0 wrap for free.
  assign word_idx = start_q + beat_q;
  assign first    = (beat_q == '0);
  assign last     = (beat_q == WORD_SEL_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Critical-word-first 4-word line refill sequencer with early word forward.
// Latency: miss->mem_req 1 cycle; beat->array write 1 cycle; last beat->done 1 cycle.
// Backpressure: mem_req held until mem_ack; beats accepted whenever mem_rvalid, any gaps.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fill_we,
  output logic [WORD_SEL_W-1:0] fill_word_sel,
  output logic [DATA_WIDTH-1:0] fill_wdata,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data,
  output logic                  tag_we,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
    ~ADDR_WIDTH'((1 << WORD_OFFSET_LSB) - 1);

  refill_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  fill_we_q, fill_we_d;
  logic [WORD_SEL_W-1:0] fill_word_sel_q, fill_word_sel_d;
  logic [DATA_WIDTH-1:0] fill_wdata_q, fill_wdata_d;
  logic                  crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0] crit_data_q, crit_data_d;
  logic                  tag_we_q, tag_we_d;

  logic                  start_miss;
  logic                  beat_acc;
  logic [WORD_SEL_W-1:0] word_idx;
  logic                  beat_first;
  logic                  beat_last;

  assign start_miss = (state_q == ST_IDLE) && miss_req;
  assign beat_acc   = (state_q == ST_FILL) && mem_rvalid;

  refill_wrap_cnt u_wrap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == ST_DONE),
    .load     (start_miss),
    .start_in (miss_addr[WORD_OFFSET_LSB +: WORD_SEL_W]),
    .inc      (beat_acc),
    .word_idx (word_idx),
    .first    (beat_first),
    .last     (beat_last)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      fill_we_q       <= 1'b0;
      fill_word_sel_q <= '0;
      fill_wdata_q    <= '0;
      crit_valid_q    <= 1'b0;
      crit_data_q     <= '0;
      tag_we_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      fill_we_q       <= fill_we_d;
      fill_word_sel_q <= fill_word_sel_d;
      fill_wdata_q    <= fill_wdata_d;
      crit_valid_q    <= crit_valid_d;
      crit_data_q     <= crit_data_d;
      tag_we_q        <= tag_we_d;
    end
  end

  // Next-state: stray ack/rvalid outside their states fall through untouched.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (miss_req) state_d = ST_REQ;
      ST_REQ:  if (mem_ack) state_d = ST_FILL;
      ST_FILL: if (beat_acc && beat_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; data outputs are zeroed whenever their strobe is low.
  always_comb begin
    addr_d          = start_miss ? miss_addr : addr_q;
    fill_we_d       = beat_acc;
    fill_word_sel_d = beat_acc ? word_idx : '0;
    fill_wdata_d    = beat_acc ? mem_rdata : '0;
    crit_valid_d    = beat_acc && beat_first;
    crit_data_d     = (beat_acc && beat_first) ? mem_rdata : '0;
    tag_we_d        = beat_acc && beat_last;
    mem_req         = (state_q == ST_REQ);
    busy            = (state_q != ST_IDLE);
  end

  assign mem_addr      = mem_req ? (addr_q & WORD_MASK) : '0;
  assign fill_we       = fill_we_q;
  assign fill_word_sel = fill_word_sel_q;
  assign fill_wdata    = fill_wdata_q;
  assign crit_valid    = crit_valid_q;
  assign crit_data     = crit_data_q;
  assign tag_we        = tag_we_q;
  assign done          = tag_we_q;

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Sequences a 4-word cache line refill from the memory port into the cache data array after a miss. It uses critical-word-first wrap order and forwards the missed word early. It drives the 2-bit word-select/enable of the data-array write path and issues the tag/valid write when the line is complete. It sits between the cache miss logic and the external memory interface, one instance per cache.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; line is fixed at 4 words
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_req  in  1  miss pending; level, held until done
- miss_addr  in  ADDR_WIDTH  missed byte address, sampled in IDLE when miss_req=1
- mem_req  out  1  memory read request, held until mem_ack
- mem_addr  out  ADDR_WIDTH  word-aligned address of critical word ({miss_addr[AW-1:2],2'b00})
- mem_ack  in  1  request accepted this cycle
- mem_rvalid  in  1  one read beat valid this cycle
- mem_rdata  in  DATA_WIDTH  read beat data
- fill_we  out  1  data-array word write enable
- fill_word_sel  out  2  word index written this cycle
- fill_wdata  out  DATA_WIDTH  word written
- crit_valid  out  1  one-cycle pulse: critical word forwarded to core
- crit_data  out  DATA_WIDTH  forwarded word (valid with crit_valid)
- tag_we  out  1  one-cycle pulse: write tag, set valid for refilled line
- busy  out  1  refill in progress (state != IDLE)
- done  out  1  one-cycle completion pulse, same cycle as tag_we

## Operation
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE: on miss_req=1, latch miss_addr, set start=miss_addr[3:2] and beat=0, then go to REQ.
- REQ: mem_req=1, mem_addr stable. On mem_ack=1, go to FILL.
- FILL: each mem_rvalid=1 accepts one beat. The beat is written to word (start+beat) mod 4, which wraps 3→0. Beat counter increments; after beat 3 is accepted, go to DONE.
- First beat (beat 0) additionally produces crit_valid/crit_data.
- DONE: tag_we=1, done=1 for one cycle, then go to IDLE unconditionally. miss_req is ignored in DONE.
- In IDLE, a miss_req still high the cycle after done starts a new refill; the requester must drop it in the done cycle.
- mem_rvalid outside FILL, including REQ before ack, is ignored: no write, counter unchanged.
- mem_ack outside REQ is ignored.
- Outputs fill_we, fill_word_sel, fill_wdata, crit_valid, crit_data, tag_we and done are registered. mem_req and busy decode from state.
- Reset (asserted at any time, including mid-FILL): state IDLE, beat 0, start 0. All outputs 0, data outputs 0. Beats arriving after reset are dropped (state IDLE).

## Timing
- miss_req high at cycle 0 → mem_req high at cycle 1.
- mem_ack at cycle k (earliest k=1) → FILL from k+1.
- mem_rvalid at cycle t in FILL → fill_we, fill_word_sel, fill_wdata at t+1. For beat 0, crit_valid is also at t+1.
- Back-to-back beats accepted one per cycle. Gaps of any length are allowed.
- Fourth beat at cycle t → last fill_we and DONE (tag_we, done) both at t+1. busy drops at t+2.
- Minimum refill: ack at cycle 1, beats at cycles 2–5, done at cycle 6, idle at cycle 7.

## Structure
- Shared package cache_pkg holds:
  - FSM state enum
  - WORDS_PER_LINE=4
  - WORD_SEL_W=2
  - WORD_OFFSET_LSB=2 (byte offset bits below the word index)
- Natural sub-module: refill_wrap_cnt, a 2-bit beat counter plus start offset. It outputs the wrapped word index and last-beat flag, with clear/load/increment controls.

## Test plan
- Aligned miss: miss_addr=0x1000, immediate ack, 4 back-to-back beats A,B,C,D → fill_word_sel 0,1,2,3 with data A..D. crit_data=A. done/tag_we 1 cycle after the D write's rvalid.
- Wrapped miss: miss_addr=0x2008 → mem_addr=0x2008. Beats written to words 2,3,0,1. crit_data = first beat.
- Stalls: ack delayed 5 cycles with mem_req held, beats with 0–3 idle gaps between them → exactly 4 fill_we pulses, correct order, busy high throughout.
- Spurious handshakes: mem_rvalid in IDLE and in REQ before ack, mem_ack in IDLE → no fill_we, no state change.
- Reset mid-FILL after 2 beats → all outputs 0 immediately. Remaining beats ignored. A fresh miss afterwards completes normally starting from beat 0.
- Re-issue: miss_req kept high through done → second refill begins with mem_req high 2 cycles after done.
